// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner.
// Each channel synchronizes an active-low raw button, debounces it, and runs
// a small FSM that produces press/release pulses, a held level and an
// optional autorepeat pulse train while the button stays down.
// `release` is a reserved word in SystemVerilog, so the release pulse output
// is named `released`.
module button_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   btn_n,
    input  logic [N-1:0]   repeat_en,
    output logic [N-1:0]   press,
    output logic [N-1:0]   released,
    output logic [N-1:0]   held,
    output logic [N-1:0]   rpt,
    output logic [2*N-1:0] state,
    output logic           any_press
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W  = $clog2(R_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LAST   = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2,
        RELEASED = 2'd3
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic            s1;
        logic            s2;
        logic            db;        // debounced level, 1 = up
        logic [DB_W-1:0] cnt;       // consecutive samples differing from db
        logic            flip;      // db changes on this edge
        state_t          st;
        logic [RP_W-1:0] rcnt;      // cycles since HELD entry / last repeat
        logic            rphase;    // 0: waiting initial delay, 1: periodic
        logic            rpt_r;

        // The flip edge is the one taking the final differing sample.
        assign flip = (s2 != db) && (cnt == DB_LAST);

        // Two-flop synchronizer feeding the debounce counter.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1  <= 1'b1;
                s2  <= 1'b1;
                db  <= 1'b1;
                cnt <= '0;
            end else begin
                s1 <= btn_n[i];
                s2 <= s1;
                if (s2 == db) begin
                    cnt <= '0;
                end else if (flip) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end
        end

        // Channel FSM, reacting on the same edge the debounced level flips,
        // plus the autorepeat timer that only runs while HELD and enabled.
        always_ff @(posedge clock) begin
            if (reset) begin
                st     <= IDLE;
                rcnt   <= '0;
                rphase <= 1'b0;
                rpt_r  <= 1'b0;
            end else begin
                rpt_r <= 1'b0;
                case (st)
                    IDLE: begin
                        if (flip && !s2) st <= PRESSED;
                    end
                    PRESSED: begin
                        st     <= HELD;
                        rcnt   <= '0;
                        rphase <= 1'b0;
                    end
                    HELD: begin
                        if (flip && s2) begin
                            st     <= RELEASED;
                            rcnt   <= '0;
                            rphase <= 1'b0;
                        end else if (!repeat_en[i]) begin
                            // Disabling restarts the initial delay later on.
                            rcnt   <= '0;
                            rphase <= 1'b0;
                        end else if (rcnt == (rphase ? PER_LAST : DELAY_LAST)) begin
                            rpt_r  <= 1'b1;
                            rcnt   <= '0;
                            rphase <= 1'b1;
                        end else begin
                            rcnt <= rcnt + RP_W'(1);
                        end
                    end
                    RELEASED: begin
                        st <= IDLE;
                    end
                endcase
            end
        end

        assign press[i]        = (st == PRESSED);
        assign released[i]     = (st == RELEASED);
        assign held[i]         = (st == PRESSED) || (st == HELD);
        assign rpt[i]          = rpt_r;
        assign state[2*i +: 2] = st;
    end

    assign any_press = |press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters
// (N=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_button_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] btn_n;
    logic [3:0] repeat_en;
    logic [3:0] press;
    logic [3:0] released;
    logic [3:0] held;
    logic [3:0] rpt;
    logic [7:0] state;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    button_conditioner dut (
        .clock     (clock),
        .reset     (reset),
        .btn_n     (btn_n),
        .repeat_en (repeat_en),
        .press     (press),
        .released  (released),
        .held      (held),
        .rpt       (rpt),
        .state     (state),
        .any_press (any_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One active edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_press"}, 32'(press), 32'h0);
        check({tag, "_release"}, 32'(released), 32'h0);
        check({tag, "_held"}, 32'(held), 32'h0);
        check({tag, "_rpt"}, 32'(rpt), 32'h0);
        check({tag, "_state"}, 32'(state), 32'h0);
        check({tag, "_any"}, 32'(any_press), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        btn_n     = 4'b1111;
        repeat_en = 4'b0000;
        tick();
        tick();
        check_quiet("in_reset");
        reset = 1'b0;
        tick();
        tick();
        check_quiet("after_reset");

        // Channel 0 press: low first sampled at edge 0, press after edge 5.
        btn_n = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ch0_press_early", 32'(press), 32'h0);
            check("ch0_held_early", 32'(held), 32'h0);
        end
        tick();
        check("ch0_press", 32'(press), 32'h1);
        check("ch0_any", 32'(any_press), 32'h1);
        check("ch0_state_pressed", 32'(state), 32'h01);
        check("ch0_held", 32'(held), 32'h1);
        tick();
        check("ch0_press_gone", 32'(press), 32'h0);
        check("ch0_state_held", 32'(state), 32'h02);
        check("ch0_held2", 32'(held), 32'h1);
        check("ch0_no_rpt", 32'(rpt), 32'h0);

        // Channel 0 release with the same latency.
        btn_n = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ch0_rel_early", 32'(released), 32'h0);
            check("ch0_held_until_rel", 32'(held), 32'h1);
        end
        tick();
        check("ch0_release", 32'(released), 32'h1);
        check("ch0_state_released", 32'(state), 32'h03);
        check("ch0_held_off", 32'(held), 32'h0);
        tick();
        check_quiet("ch0_idle");

        // Channel 1 glitch of 3 cycles: no effect at all.
        btn_n = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ch1_glitch_state", 32'(state), 32'h0);
        end
        btn_n = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_quiet("ch1_glitch");
        end

        // Channel 2 autorepeat: HELD entered at edge 6.
        repeat_en = 4'b0100;
        btn_n     = 4'b1011;
        for (int k = 0; k < 6; k++) tick();
        check("ch2_press", 32'(press), 32'h4);
        check("ch2_press_rpt", 32'(rpt), 32'h0);
        tick();
        check("ch2_state_held", 32'(state), 32'h20);
        check("ch2_rpt_entry", 32'(rpt), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("ch2_rpt_k%0d", k), 32'(rpt),
                  (k == 10 || k == 13 || k == 16) ? 32'h4 : 32'h0);
        end
        repeat_en = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ch2_rpt_disabled", 32'(rpt), 32'h0);
        end
        check("ch2_still_held", 32'(held), 32'h4);
        repeat_en = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ch2_rpt_reen_k%0d", k), 32'(rpt), (k == 10) ? 32'h4 : 32'h0);
        end
        repeat_en = 4'b0000;
        btn_n     = 4'b1111;
        for (int k = 0; k < 5; k++) tick();
        check("ch2_rel_early", 32'(released), 32'h0);
        tick();
        check("ch2_release", 32'(released), 32'h4);
        check("ch2_release_rpt", 32'(rpt), 32'h0);
        tick();
        check_quiet("ch2_idle");

        // Channels 0 and 3 together.
        btn_n = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ch03_press_early", 32'(press), 32'h0);
        end
        tick();
        check("ch03_press", 32'(press), 32'h9);
        check("ch03_any", 32'(any_press), 32'h1);
        check("ch03_state", 32'(state), 32'hC3 & 32'h41);
        tick();
        check("ch03_press_gone", 32'(press), 32'h0);
        check("ch03_any_gone", 32'(any_press), 32'h0);
        check("ch03_held", 32'(held), 32'h9);
        tick();
        tick();
        btn_n = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ch03_rel_early", 32'(released), 32'h0);
        end
        tick();
        check("ch03_release", 32'(released), 32'h9);
        check("ch03_state_rel", 32'(state), 32'hC3);
        tick();
        check_quiet("ch03_idle");

        // Reset while channel 0 is HELD and the button stays down.
        btn_n = 4'b1110;
        for (int k = 0; k < 7; k++) tick();
        check("rst_pre_state", 32'(state), 32'h02);
        reset = 1'b1;
        tick();
        check_quiet("rst_mid_hold");
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rst_no_release", 32'(released), 32'h0);
            check("rst_press_early", 32'(press), 32'h0);
        end
        tick();
        check("rst_repress", 32'(press), 32'h1);
        check("rst_repress_state", 32'(state), 32'h01);
        btn_n = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        check_quiet("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
